// File: rtl/shift_sched.sv
// shift_sched: two-requester arbiter feeding one shared 5-stage log shifter.
// Ports: clock/reset_n (async low); req0_*/req1_* valid/ready/data/shamt/op;
// rsp_valid/rsp_ready/rsp_data/rsp_id result; busy, op_count status.
// Build option: define SHIFT_SCHED_RR_EN for round-robin arbitration,
// otherwise requester 0 always has priority.
module shift_sched (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opd_q, opd_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        op_q, op_d;
  logic        id_q, id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] op_count_q, op_count_d;
  logic        gnt_id;
  logic        accept;
  logic [31:0] shf;
`ifdef SHIFT_SCHED_RR_EN
  logic        ptr_q, ptr_d;
`endif

  // gnt_id names the requester that wins if anyone is valid
  always_comb begin
`ifdef SHIFT_SCHED_RR_EN
    gnt_id = (req0_valid && req1_valid) ? ptr_q : !req0_valid;
`else
    gnt_id = !req0_valid;
`endif
  end

  assign req0_ready = reset_n && (state_q == IDLE)
                      && req0_valid && !gnt_id;
  assign req1_ready = reset_n && (state_q == IDLE)
                      && req1_valid && gnt_id;
  assign accept     = req0_ready || req1_ready;

  // Log shifter: stage i shifts by 2**i when shamt bit i is set
  always_comb begin
    shf = opd_q;
    for (int i = 0; i < 5; i++) begin
      if (shamt_q[i]) begin
        if (op_q) shf = $unsigned($signed(shf) >>> (1 << i));
        else      shf = shf << (1 << i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    opd_d       = opd_q;
    shamt_d     = shamt_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    op_count_d  = op_count_q;
`ifdef SHIFT_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opd_d   = gnt_id ? req1_data  : req0_data;
          shamt_d = gnt_id ? req1_shamt : req0_shamt;
          op_d    = gnt_id ? req1_op    : req0_op;
          id_d    = gnt_id;
          state_d = SHIFT;
          busy_d  = 1'b1;
`ifdef SHIFT_SCHED_RR_EN
          ptr_d   = !gnt_id;
`endif
        end
      end
      SHIFT: begin
        rsp_data_d  = shf;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      opd_q       <= '0;
      shamt_q     <= '0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
`ifdef SHIFT_SCHED_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opd_q       <= opd_d;
      shamt_q     <= shamt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
`ifdef SHIFT_SCHED_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule
